// File: rtl/call_registry.sv
// Elevator call registry: synchronises and debounces every cabin/hall button, latches each
// press until serviced, and keeps registered above/below/here/count summaries of pending calls.
module call_registry #(
  parameter int N_FLOORS        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FLOOR_W         = $clog2(N_FLOORS),
  parameter int CNT_W           = $clog2(3*N_FLOORS-1)
) (
  input  logic                clk,
  input  logic                an_reset,
  input  logic [N_FLOORS-1:0] btn_in,
  input  logic [N_FLOORS-2:0] btn_up_out,
  input  logic [N_FLOORS-1:1] btn_down_out,
  input  logic [N_FLOORS-1:0] inactivate_in_levels,
  input  logic [N_FLOORS-2:0] inactivate_out_up_levels,
  input  logic [N_FLOORS-1:1] inactivate_out_down_levels,
  input  logic [FLOOR_W-1:0]  current_floor,
  output logic [N_FLOORS-1:0] active_in_levels,
  output logic [N_FLOORS-2:0] active_out_up_levels,
  output logic [N_FLOORS-1:1] active_out_down_levels,
  output logic                req_above,
  output logic                req_below,
  output logic                req_here,
  output logic [CNT_W-1:0]    pending_count
);

  localparam int N_CH  = 3*N_FLOORS - 2;
  localparam int UP_LO = N_FLOORS;
  localparam int DN_LO = 2*N_FLOORS - 1;
  localparam int DCW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]     raw;
  logic [N_CH-1:0]     clr;
  logic [N_CH-1:0]     sync_p0;
  logic [N_CH-1:0]     sync_p1;
  logic [N_CH-1:0]     deb_p2;
  logic [DCW-1:0]      cnt_p2 [N_CH];
  logic [N_CH-1:0]     rise;
  logic [N_CH-1:0]     act_p3;
  logic [N_CH-1:0]     act_nxt;
  logic [N_FLOORS-1:0] floor_any;
  logic                above_nxt;
  logic                below_nxt;
  logic                here_nxt;
  logic [CNT_W-1:0]    count_nxt;

  function automatic logic [CNT_W-1:0] count_ones(input logic [N_CH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Channel layout: cabin [N-1:0], hall up [2N-2:N], hall down [3N-3:2N-1]
  assign raw = {btn_down_out, btn_up_out, btn_in};
  assign clr = {inactivate_out_down_levels, inactivate_out_up_levels, inactivate_in_levels};

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk or negedge an_reset) begin
    if (!an_reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; any toggle before acceptance restarts the count
  always_ff @(posedge clk or negedge an_reset) begin
    if (!an_reset) begin
      deb_p2 <= '0;
      for (int i = 0; i < N_CH; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          deb_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + DCW'(1);
        end
      end
    end
  end

  // A call is set on the edge where deb is about to rise; set beats a same-edge clear.
  always_comb begin
    rise = '0;
    for (int i = 0; i < N_CH; i++)
      rise[i] = (sync_p1[i] != deb_p2[i]) && (cnt_p2[i] == CNT_LAST) && sync_p1[i];
    act_nxt = (act_p3 & ~clr) | rise;
  end

  always_comb begin
    int cf;
    cf        = int'(current_floor);
    floor_any = act_nxt[N_FLOORS-1:0];
    for (int f = 0; f < N_FLOORS-1; f++) begin
      floor_any[f]   = floor_any[f]   | act_nxt[UP_LO+f];
      floor_any[f+1] = floor_any[f+1] | act_nxt[DN_LO+f];
    end
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    here_nxt  = 1'b0;
    // An out-of-range floor sits above every real floor, so only req_below can fire.
    for (int f = 0; f < N_FLOORS; f++) begin
      if (floor_any[f]) begin
        if (f > cf)  above_nxt = 1'b1;
        if (f < cf)  below_nxt = 1'b1;
        if (f == cf) here_nxt  = 1'b1;
      end
    end
    count_nxt = count_ones(act_nxt);
  end

  // Stage p3: latched calls and summaries, aligned in the same cycle
  always_ff @(posedge clk or negedge an_reset) begin
    if (!an_reset) begin
      act_p3        <= '0;
      req_above     <= 1'b0;
      req_below     <= 1'b0;
      req_here      <= 1'b0;
      pending_count <= '0;
    end else begin
      act_p3        <= act_nxt;
      req_above     <= above_nxt;
      req_below     <= below_nxt;
      req_here      <= here_nxt;
      pending_count <= count_nxt;
    end
  end

  assign active_in_levels       = act_p3[N_FLOORS-1:0];
  assign active_out_up_levels   = act_p3[DN_LO-1:UP_LO];
  assign active_out_down_levels = act_p3[N_CH-1:DN_LO];

endmodule

// File: tb/tb_call_registry.sv
// Scoreboard bench for call_registry (8 floors, 4-cycle debounce, 4-bit floor input).
module tb_call_registry;

  logic       clk = 1'b0;
  logic       an_reset = 1'b0;
  logic [7:0] btn_in = '0;
  logic [6:0] btn_up_out = '0;
  logic [7:1] btn_down_out = '0;
  logic [7:0] inactivate_in_levels = '0;
  logic [6:0] inactivate_out_up_levels = '0;
  logic [7:1] inactivate_out_down_levels = '0;
  logic [3:0] current_floor = '0;
  logic [7:0] active_in_levels;
  logic [6:0] active_out_up_levels;
  logic [7:1] active_out_down_levels;
  logic       req_above;
  logic       req_below;
  logic       req_here;
  logic [4:0] pending_count;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    string       name;
    int          at;
    logic [29:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  localparam logic [29:0] ZERO = 30'h0;

  call_registry #(
    .N_FLOORS(8),
    .DEBOUNCE_CYCLES(4),
    .FLOOR_W(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .an_reset(an_reset),
    .btn_in(btn_in),
    .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out),
    .inactivate_in_levels(inactivate_in_levels),
    .inactivate_out_up_levels(inactivate_out_up_levels),
    .inactivate_out_down_levels(inactivate_out_down_levels),
    .current_floor(current_floor),
    .active_in_levels(active_in_levels),
    .active_out_up_levels(active_out_up_levels),
    .active_out_down_levels(active_out_down_levels),
    .req_above(req_above),
    .req_below(req_below),
    .req_here(req_here),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [29:0] obs();
    return {active_out_down_levels, active_out_up_levels, active_in_levels,
            req_above, req_below, req_here, pending_count};
  endfunction

  function automatic logic [29:0] mk(logic [6:0] dn, logic [6:0] up, logic [7:0] in_v,
                                     logic a, logic b, logic h, logic [4:0] c);
    return {dn, up, in_v, a, b, h, c};
  endfunction

  task automatic push(string n, int dly, logic [29:0] v);
    sb.push_back('{name: n, at: cyc + dly, val: v});
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btn_in = '0;
    btn_up_out = '0;
    btn_down_out = '0;
    inactivate_in_levels = '0;
    inactivate_out_up_levels = '0;
    inactivate_out_down_levels = '0;
    current_floor = '0;
    an_reset = 1'b0;
    tick(2);
    an_reset = 1'b1;
  endtask

  task automatic test_reset();
    an_reset = 1'b0;
    btn_in = 8'hFF;
    tick(3);
    push("reset_hold", 0, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_in = '0;
    an_reset = 1'b1;
    push("reset_release", 8, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
  endtask

  task automatic test_cabin_latch();
    logic [29:0] v;
    do_reset();
    v = mk(7'h00, 7'h00, 8'h08, 1'b1, 1'b0, 1'b0, 5'd1);
    btn_in[3] = 1'b1;
    push("cabin_edge5", 5, ZERO);
    push("cabin_edge6", 6, v);
    push("cabin_held", 10, v);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_in[3] = 1'b0;
    push("cabin_released", 8, v);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_up_out[2] = 1'b1;
    tick(2);
    btn_up_out[2] = 1'b0;
    push("glitch_2cyc", 10, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_up_out[2] = 1'b1;
    tick(3);
    btn_up_out[2] = 1'b0;
    push("glitch_3cyc", 10, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_up_out[2] = 1'b1;
    push("pulse5_edge5", 5, ZERO);
    push("pulse5_edge6", 6, mk(7'h00, 7'h04, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1));
    tick(5);
    btn_up_out[2] = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
  endtask

  task automatic test_summary();
    do_reset();
    current_floor = 4'd4;
    btn_in[1] = 1'b1;
    btn_up_out[4] = 1'b1;
    btn_down_out[6] = 1'b1;
    push("three_calls", 6, mk(7'h20, 7'h10, 8'h02, 1'b1, 1'b1, 1'b1, 5'd3));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_in = '0;
    btn_up_out = '0;
    btn_down_out = '0;
    inactivate_out_up_levels[4] = 1'b1;
    tick(1);
    inactivate_out_up_levels = '0;
    push("clear_up4", 0, mk(7'h20, 7'h00, 8'h02, 1'b1, 1'b1, 1'b0, 5'd2));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    btn_down_out[5] = 1'b1;
    tick(5);
    inactivate_out_down_levels[5] = 1'b1;
    push("set_wins", 1, mk(7'h10, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1));
    push("clear_next", 2, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    inactivate_out_down_levels = '0;
    push("held_no_reset", 4, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_down_out = '0;
  endtask

  task automatic test_all_buttons();
    do_reset();
    current_floor = 4'd7;
    btn_in = 8'hFF;
    btn_up_out = 7'h7F;
    btn_down_out = 7'h7F;
    push("all_edge5", 5, ZERO);
    push("all_calls", 6, mk(7'h7F, 7'h7F, 8'hFF, 1'b0, 1'b1, 1'b1, 5'd22));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    current_floor = 4'd0;
    push("all_floor0", 1, mk(7'h7F, 7'h7F, 8'hFF, 1'b1, 1'b0, 1'b1, 5'd22));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    inactivate_in_levels = 8'hFF;
    inactivate_out_up_levels = 7'h7F;
    inactivate_out_down_levels = 7'h7F;
    push("clear_all", 1, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    inactivate_in_levels = '0;
    inactivate_out_up_levels = '0;
    inactivate_out_down_levels = '0;
    push("held_stays_clear", 3, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_in = '0;
    btn_up_out = '0;
    btn_down_out = '0;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    btn_in[2] = 1'b1;
    btn_up_out[0] = 1'b1;
    push("pre_reset", 6, mk(7'h00, 7'h01, 8'h04, 1'b1, 1'b0, 1'b1, 5'd2));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_up_out = '0;
    tick(2);
    #2 an_reset = 1'b0;
    #1;
    push("async_clear", 0, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    current_floor = 4'd9;
    tick(3);
    push("in_reset", 0, ZERO);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    an_reset = 1'b1;
    push("redebounce_edge5", 5, ZERO);
    push("redebounce_edge6", 6, mk(7'h00, 7'h00, 8'h04, 1'b0, 1'b1, 1'b0, 5'd1));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      while (cyc < e.at) @(negedge clk);
      total++;
      if (obs() !== e.val) $display("FAIL %s: got %h expected %h", e.name, obs(), e.val);
      else passed++;
    end
    btn_in = '0;
  endtask

  initial begin
    test_reset();
    test_cabin_latch();
    test_glitch();
    test_summary();
    test_set_wins();
    test_all_buttons();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", passed, total);
    $fatal(1);
  end

endmodule
